// File: rtl/osc_freq_meter_pkg.sv
// Shared types and helpers for the oscillator frequency meter.
package osc_freq_meter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int lock_cnt_w(input int lock_n);
    return $clog2(lock_n + 1);
  endfunction

  // Increment that sticks at max_v instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
    return (v >= max_v) ? max_v : v + 32'd1;
  endfunction

endpackage

// File: rtl/osc_edge_sync.sv
// Two-flop synchroniser for one oscillator input followed by a registered
// rising-edge detector; pulse_o is one clk wide, three cycles after the input edge.
module osc_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic osc_in,
  output logic pulse_o
);

  logic [2:0] sync_q, sync_d;
  logic       pulse_q, pulse_d;

  always_comb begin
    sync_d  = {sync_q[1:0], osc_in};
    pulse_d = sync_q[1] & ~sync_q[2];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/osc_freq_meter.sv
// Multi-channel gated edge counter with tolerance compare and lock detection
// for the ring-oscillator PLL measurement path.
module osc_freq_meter
  import osc_freq_meter_pkg::*;
#(
  parameter int NCH    = 4,
  parameter int CNT_W  = 16,
  parameter int WIN_W  = 16,
  parameter int LOCK_N = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH-1:0]       osc_in,
  input  logic [NCH-1:0]       chan_en,
  input  logic [WIN_W-1:0]     win_len,
  input  logic [CNT_W-1:0]     target,
  input  logic [CNT_W-1:0]     tol,
  input  logic                 start,
  input  logic                 cont_mode,
  input  logic                 abort,
  output logic                 busy,
  output logic                 done,
  output logic [NCH*CNT_W-1:0] count_o,
  output logic [NCH-1:0]       in_range,
  output logic                 locked
);

  localparam int              LCW      = lock_cnt_w(LOCK_N);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [LCW-1:0]   LOCK_MAX = LCW'(LOCK_N);

  state_e               state_q, state_d;
  logic [WIN_W-1:0]     win_q, win_d, win_init;
  logic [CNT_W-1:0]     cnt_q [NCH];
  logic [CNT_W-1:0]     cnt_d [NCH];
  logic [CNT_W-1:0]     cnt_inc [NCH];
  logic [NCH*CNT_W-1:0] count_q, count_d;
  logic [NCH-1:0]       in_range_q, in_range_d, range_ok, pulse;
  logic [LCW-1:0]       lock_cnt_q, lock_cnt_d;
  logic                 locked_q, locked_d, busy_q, busy_d, done_q, done_d;
  logic                 pass;

  // cnt_inc already includes this cycle's edge so the last RUN cycle is counted.
  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic signed [CNT_W:0] diff;
    logic        [CNT_W:0] mag;

    osc_edge_sync u_sync (
      .clk     (clk),
      .rst     (rst),
      .osc_in  (osc_in[g]),
      .pulse_o (pulse[g])
    );

    assign cnt_inc[g]  = pulse[g] ? CNT_W'(sat_inc(32'(cnt_q[g]), 32'(CNT_MAX))) : cnt_q[g];
    assign diff        = $signed({1'b0, cnt_inc[g]}) - $signed({1'b0, target});
    assign mag         = diff[CNT_W] ? $unsigned(-diff) : $unsigned(diff);
    assign range_ok[g] = (mag <= {1'b0, tol});
  end

  assign win_init = (win_len == '0) ? '0 : win_len - WIN_W'(1);
  assign pass     = (chan_en != '0) && ((range_ok & chan_en) == chan_en);

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start) state_d = RUN;
        RUN:     if (win_q == '0) state_d = DONE;
        DONE:    state_d = cont_mode ? RUN : IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    win_d      = win_q;
    cnt_d      = cnt_q;
    count_d    = count_q;
    in_range_d = in_range_q;
    lock_cnt_d = lock_cnt_q;
    locked_d   = locked_q;
    done_d     = 1'b0;
    busy_d     = (state_d != IDLE);

    if (state_d == RUN && state_q != RUN) begin
      win_d = win_init;
      for (int i = 0; i < NCH; i++) cnt_d[i] = '0;
    end else if (state_q == RUN) begin
      if (win_q != '0) win_d = win_q - WIN_W'(1);
      for (int i = 0; i < NCH; i++) cnt_d[i] = cnt_inc[i];
    end

    if (state_q == RUN && state_d == DONE) begin
      done_d     = 1'b1;
      in_range_d = range_ok;
      for (int i = 0; i < NCH; i++) count_d[i*CNT_W +: CNT_W] = cnt_inc[i];
      lock_cnt_d = pass ? LCW'(sat_inc(32'(lock_cnt_q), 32'(LOCK_N))) : '0;
      locked_d   = pass && (lock_cnt_d == LOCK_MAX);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      win_q      <= '0;
      count_q    <= '0;
      in_range_q <= '0;
      lock_cnt_q <= '0;
      locked_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      win_q      <= win_d;
      count_q    <= count_d;
      in_range_q <= in_range_d;
      lock_cnt_q <= lock_cnt_d;
      locked_q   <= locked_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Edge counters are always cleared on entry to RUN, so they need no reset.
  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign count_o  = count_q;
  assign in_range = in_range_q;
  assign locked   = locked_q;

endmodule

// File: tb/tb_osc_freq_meter.sv
// Scoreboard bench: stimulus pushes expected window results, a monitor pops
// and compares them on every done pulse of either meter instance.
module tb_osc_freq_meter;

  localparam int NCH = 4;

  typedef struct {
    int         done_cyc;
    int         ch;
    int         lo;
    int         hi;
    logic [3:0] inr;
    logic       lk;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic [7:0] osc = '0;
  int per [8];
  int ph  [8];
  int cyc = 0;
  int n_run = 0;
  int n_fail = 0;
  exp_t q_m[$];
  exp_t q_s[$];
  exp_t em, es;

  // main instance (16-bit counts)
  logic [NCH-1:0]   chan_en, in_range;
  logic [15:0]      win_len, target, tol;
  logic             start, cont_mode, abort, busy, done, locked;
  logic [NCH*16-1:0] count_o;

  // saturation instance (4-bit counts)
  logic [NCH-1:0]   chan_en_s, in_range_s;
  logic [15:0]      win_len_s;
  logic [3:0]       target_s, tol_s;
  logic             start_s, busy_s, done_s, locked_s;
  logic [NCH*4-1:0] count_s;

  osc_freq_meter #(.NCH(NCH), .CNT_W(16), .WIN_W(16), .LOCK_N(4)) dut (
    .clk(clk), .rst(rst), .osc_in(osc[3:0]), .chan_en(chan_en), .win_len(win_len),
    .target(target), .tol(tol), .start(start), .cont_mode(cont_mode), .abort(abort),
    .busy(busy), .done(done), .count_o(count_o), .in_range(in_range), .locked(locked)
  );

  osc_freq_meter #(.NCH(NCH), .CNT_W(4), .WIN_W(16), .LOCK_N(4)) dut_s (
    .clk(clk), .rst(rst), .osc_in(osc[7:4]), .chan_en(chan_en_s), .win_len(win_len_s),
    .target(target_s), .tol(tol_s), .start(start_s), .cont_mode(1'b0), .abort(1'b0),
    .busy(busy_s), .done(done_s), .count_o(count_s), .in_range(in_range_s), .locked(locked_s)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Square-wave oscillators with periods in clk cycles; 0 holds the line low.
  always @(negedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (per[i] == 0) begin
        ph[i]  = 0;
        osc[i] = 1'b0;
      end else begin
        ph[i]  = (ph[i] + 1) % per[i];
        osc[i] = (ph[i] < per[i] / 2);
      end
    end
  end

  task automatic chk(input string nm, input longint act, input longint req);
    n_run++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic chk_rng(input string nm, input longint act, input longint lo, input longint hi);
    n_run++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d..%0d (cycle %0d)", nm, act, lo, hi, cyc);
    end
  endtask

  task automatic push_m(input int dc, input int ch, input int lo, input int hi,
                        input logic [3:0] inr, input logic lk);
    exp_t e;
    e.done_cyc = dc; e.ch = ch; e.lo = lo; e.hi = hi; e.inr = inr; e.lk = lk;
    q_m.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor for the main instance
  always @(negedge clk) begin
    if (!rst && done) begin
      if (q_m.size() == 0) begin
        n_run++; n_fail++;
        $display("FAIL unexpected_done_main: done=1 at cycle %0d, required done=0", cyc);
      end else begin
        em = q_m.pop_front();
        chk("done_cycle_main", cyc, em.done_cyc);
        for (int i = 0; i < NCH; i++) begin
          if (i == em.ch) chk_rng("count_meas_main", count_o[i*16 +: 16], em.lo, em.hi);
          else            chk("count_idle_main", count_o[i*16 +: 16], 0);
        end
        chk("in_range_main", in_range, em.inr);
        chk("locked_main", locked, em.lk);
      end
    end
  end

  // Monitor for the saturation instance
  always @(negedge clk) begin
    if (!rst && done_s) begin
      if (q_s.size() == 0) begin
        n_run++; n_fail++;
        $display("FAIL unexpected_done_sat: done=1 at cycle %0d, required done=0", cyc);
      end else begin
        es = q_s.pop_front();
        chk("done_cycle_sat", cyc, es.done_cyc);
        for (int i = 0; i < NCH; i++) begin
          if (i == es.ch) chk_rng("count_meas_sat", count_s[i*4 +: 4], es.lo, es.hi);
          else            chk("count_idle_sat", count_s[i*4 +: 4], 0);
        end
        chk("in_range_sat", in_range_s, es.inr);
        chk("locked_sat", locked_s, es.lk);
      end
    end
  end

  initial begin
    int t0;
    exp_t e;
    for (int i = 0; i < 8; i++) begin per[i] = 0; ph[i] = 0; end
    rst = 1'b1; start = 1'b0; cont_mode = 1'b0; abort = 1'b0;
    chan_en = '0; win_len = '0; target = '0; tol = '0;
    start_s = 1'b0; chan_en_s = '0; win_len_s = '0; target_s = '0; tol_s = '0;
    tick(3);
    rst = 1'b0;
    tick(2);

    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_count", count_o, 0);
    chk("reset_in_range", in_range, 0);
    chk("reset_locked", locked, 0);
    chk("reset_count_sat", count_s, 0);

    // Count accuracy (ch0, period 8, 800 cycles) and 4-bit saturation (ch1, period 4, 200 cycles)
    per[0] = 8; per[5] = 4;
    win_len = 800; target = 100; tol = 5; chan_en = 4'b0001;
    win_len_s = 200; target_s = 4'd15; tol_s = 4'd1; chan_en_s = 4'b0010;
    tick(20);
    t0 = cyc;
    push_m(t0 + 801, 0, 99, 101, 4'b0001, 1'b0);
    e.done_cyc = t0 + 201; e.ch = 1; e.lo = 15; e.hi = 15; e.inr = 4'b0010; e.lk = 1'b0;
    q_s.push_back(e);
    start = 1'b1; start_s = 1'b1;
    tick(1);
    start = 1'b0; start_s = 1'b0;
    chk("busy_after_start", busy, 1);
    tick(t0 + 802 - cyc);
    chk("busy_fall_oneshot", busy, 0);

    // Minimal windows: win_len 0 and 1 both give a single RUN cycle
    per[0] = 0;
    tick(10);
    win_len = 0; target = 0; tol = 0; chan_en = 4'b0000;
    t0 = cyc;
    push_m(t0 + 2, 0, 0, 0, 4'b1111, 1'b0);
    start = 1'b1; tick(1); start = 1'b0;
    tick(5);
    win_len = 1; target = 5;
    t0 = cyc;
    push_m(t0 + 2, 0, 0, 0, 4'b0000, 1'b0);
    start = 1'b1; tick(1); start = 1'b0;
    tick(5);

    // Continuous mode: lock after 4 passing windows, then abort mid-window
    per[0] = 8;
    tick(20);
    win_len = 80; target = 10; tol = 2; chan_en = 4'b0001; cont_mode = 1'b1;
    t0 = cyc;
    for (int k = 1; k <= 4; k++) push_m(t0 + 81 * k, 0, 9, 11, 4'b0001, (k == 4));
    start = 1'b1; tick(1); start = 1'b0;
    tick(t0 + 4 * 81 + 50 - cyc);
    abort = 1'b1; cont_mode = 1'b0;
    tick(1);
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_locked_kept", locked, 1);
    chk("abort_in_range_kept", in_range, 4'b0001);
    chk_rng("abort_count_kept", count_o[15:0], 9, 11);
    tick(100);

    // abort and start together in IDLE: remains idle
    abort = 1'b1; start = 1'b1;
    tick(1);
    abort = 1'b0; start = 1'b0;
    chk("abort_start_busy", busy, 0);
    tick(4);
    chk("abort_start_idle", busy, 0);

    // One-shot window while lock counter is saturated keeps locked
    t0 = cyc;
    push_m(t0 + 81, 0, 9, 11, 4'b0001, 1'b1);
    start = 1'b1; tick(1); start = 1'b0;
    tick(t0 + 82 - cyc);
    chk("busy_fall_locked_run", busy, 0);

    // Reset during RUN with locked=1 clears outputs at once
    win_len = 800;
    start = 1'b1; tick(1); start = 1'b0;
    tick(48);
    rst = 1'b1;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_count", count_o, 0);
    chk("rst_in_range", in_range, 0);
    chk("rst_locked", locked, 0);
    @(negedge clk);
    rst = 1'b0;
    tick(10);
    chk("rst_stays_idle", busy, 0);

    // Relock from zero, then shift ch0 out of range: lock drops; cont_mode off ends the run
    win_len = 80; cont_mode = 1'b1;
    t0 = cyc;
    for (int k = 1; k <= 4; k++) push_m(t0 + 81 * k, 0, 9, 11, 4'b0001, (k == 4));
    push_m(t0 + 405, 0, 15, 22, 4'b0000, 1'b0);
    start = 1'b1; tick(1); start = 1'b0;
    tick(t0 + 325 - cyc);
    per[0] = 4; cont_mode = 1'b0;
    tick(t0 + 406 - cyc);
    chk("busy_fall_after_cont_off", busy, 0);
    tick(10);

    chk("pending_main", q_m.size(), 0);
    chk("pending_sat", q_s.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
